lc3_uart_tx: RTL and testbench

- 8N1-style UART transmitter (1 start bit, 8 data bits LSB-first, optional parity, 1 or 2 stop bits).
- Serialises one byte per accepted request on a single TX line.
- Used in the LC3 system to drive the board UART TX pin.
- Also used as a host-side stimulus generator that feeds commands (e.g. run command 0x02) into the LC3 RX pin at 115200 baud from a 12 MHz clock.

---
 rtl/lc3_uart_pkg.sv | 21 ++
 rtl/lc3_baud_tick.sv | 30 +++
 rtl/lc3_uart_tx.sv | 153 +++++++++++++++
 tb/tb_lc3_uart_tx.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/lc3_uart_pkg.sv
// Shared definitions for the LC3 UART blocks: FSM states, parity modes and
// the baud divisor helper used by both TX and RX.
package lc3_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/lc3_baud_tick.sv
// Bit-period timer: one-cycle tick every DIV enabled cycles, restartable so a
// new frame always begins on a fresh bit period.
module lc3_baud_tick #(
    parameter int DIV = 104
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    input  logic i_en,
    output logic o_tick
);

    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_restart) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    assign o_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/lc3_uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity and
// one or two stop bits. tx and tx_busy come straight from flops.
module lc3_uart_tx
    import lc3_uart_pkg::*;
#(
    parameter int CLK_FREQ  = 12_000_000,
    parameter int BAUD      = 115_200,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy
);

    localparam int DIV = baud_div(CLK_FREQ, BAUD);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic PAR_INV = (PARITY == PAR_ODD);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("lc3_uart_tx: CLK_FREQ/BAUD must be at least 2");
        end
        if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_par
            $error("lc3_uart_tx: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("lc3_uart_tx: STOP_BITS must be 1 or 2");
        end
    endgenerate

    uart_state_e r_state, w_state_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic [2:0]  r_bit_idx, w_bit_idx_nxt;
    logic        r_par, w_par_nxt;
    logic        r_tx, w_tx_nxt;
    logic        r_busy, w_busy_nxt;
    logic        w_accept;
    logic        w_tick;
    logic        w_active;

    assign w_active = (r_state != IDLE);

    lc3_baud_tick #(
        .DIV(DIV)
    ) u_tick (
        .clk       (clk),
        .rst       (rst),
        .i_restart (w_accept),
        .i_en      (w_active),
        .o_tick    (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_par     <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_par     <= w_par_nxt;
            r_tx      <= w_tx_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // Next-state logic computes the value tx will hold after the edge.
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_idx_nxt = r_bit_idx;
        w_par_nxt     = r_par;
        w_tx_nxt      = r_tx;
        w_busy_nxt    = r_busy;
        w_accept      = 1'b0;

        case (r_state)
            IDLE: begin
                w_tx_nxt   = 1'b1;
                w_busy_nxt = 1'b0;
                if (tx_start) begin
                    w_accept      = 1'b1;
                    w_state_nxt   = START;
                    w_shift_nxt   = tx_data;
                    w_par_nxt     = (^tx_data) ^ PAR_INV;
                    w_bit_idx_nxt = '0;
                    w_tx_nxt      = 1'b0;
                    w_busy_nxt    = 1'b1;
                end
            end
            START: begin
                if (w_tick) begin
                    w_state_nxt = DATA;
                    w_tx_nxt    = r_shift[0];
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == 3'd7) begin
                        w_bit_idx_nxt = '0;
                        if (PARITY != PAR_NONE) begin
                            w_state_nxt = lc3_uart_pkg::PARITY;
                            w_tx_nxt    = r_par;
                        end else begin
                            w_state_nxt = STOP;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        w_shift_nxt   = r_shift >> 1;
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_tx_nxt      = r_shift[1];
                    end
                end
            end
            lc3_uart_pkg::PARITY: begin
                if (w_tick) begin
                    w_state_nxt   = STOP;
                    w_bit_idx_nxt = '0;
                    w_tx_nxt      = 1'b1;
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_bit_idx == LAST_STOP) begin
                        w_state_nxt   = IDLE;
                        w_bit_idx_nxt = '0;
                        w_busy_nxt    = 1'b0;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                    w_tx_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign tx      = r_tx;
    assign tx_busy = r_busy;

endmodule

// File: tb/tb_lc3_uart_tx.sv
// Self-checking bench for lc3_uart_tx: four parameterisations, scoreboarded
// expected frames decoded from the serial line cycle by cycle.
module tb_lc3_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] start_v;
    logic [7:0] data_v [4];
    wire  [3:0] tx_v;
    wire  [3:0] busy_v;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [11:0] bits;
        int          nbits;
        int          div;
    } frame_t;

    frame_t sb[$];

    always #5 clk = ~clk;

    lc3_uart_tx #(.CLK_FREQ(12_000_000), .BAUD(115_200), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .tx_start(start_v[0]), .tx_data(data_v[0]),
        .tx(tx_v[0]), .tx_busy(busy_v[0]));
    lc3_uart_tx #(.CLK_FREQ(12_000_000), .BAUD(115_200), .PARITY(1), .STOP_BITS(2)) u1 (
        .clk(clk), .rst(rst), .tx_start(start_v[1]), .tx_data(data_v[1]),
        .tx(tx_v[1]), .tx_busy(busy_v[1]));
    lc3_uart_tx #(.CLK_FREQ(12_000_000), .BAUD(115_200), .PARITY(2), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .tx_start(start_v[2]), .tx_data(data_v[2]),
        .tx(tx_v[2]), .tx_busy(busy_v[2]));
    lc3_uart_tx #(.CLK_FREQ(1_000_000), .BAUD(300_000), .PARITY(0), .STOP_BITS(1)) u3 (
        .clk(clk), .rst(rst), .tx_start(start_v[3]), .tx_data(data_v[3]),
        .tx(tx_v[3]), .tx_busy(busy_v[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic frame_t model(input logic [7:0] d, input int par, input int stops, input int div);
        frame_t f;
        f.bits      = '1;
        f.bits[0]   = 1'b0;
        f.bits[8:1] = d;
        f.nbits     = 9;
        if (par != 0) begin
            f.bits[9] = (par == 1) ? ^d : ~^d;
            f.nbits++;
        end
        f.nbits += stops;
        f.div   = div;
        return f;
    endfunction

    task automatic push(input logic [7:0] d, input int par, input int stops, input int div);
        sb.push_back(model(d, par, stops, div));
    endtask

    task automatic wait_start(input int inst, input int budget, output int waited);
        waited = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (tx_v[inst] === 1'b0) begin
                waited = i;
                break;
            end
        end
        chk("start_seen", 32'(waited > 0), 32'd1);
    endtask

    // Called on the first negedge of the start bit.
    task automatic check_frame(input int inst, input bit keep_start, input int chg_at,
                               input logic [7:0] chg_data, input string tag);
        frame_t      exp;
        logic [11:0] got;
        int          busy_cnt;
        int          glitch;
        int          b;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() == 0) return;
        exp      = sb.pop_front();
        got      = '1;
        busy_cnt = 0;
        glitch   = 0;
        for (int c = 0; c < exp.nbits * exp.div; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 0 && !keep_start) start_v[inst] = 1'b0;
            if (c == chg_at) data_v[inst] = chg_data;
            b = c / exp.div;
            if (c % exp.div == 0) got[b] = tx_v[inst];
            else if (tx_v[inst] !== got[b]) glitch++;
            if (busy_v[inst] === 1'b1) busy_cnt++;
        end
        @(negedge clk);
        chk({tag, "_bits"}, 32'(got), 32'(exp.bits));
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp.nbits * exp.div));
        chk({tag, "_bit_stable"}, 32'(glitch), 32'd0);
        chk({tag, "_end_busy"}, 32'(busy_v[inst]), 32'd0);
        chk({tag, "_end_tx"}, 32'(tx_v[inst]), 32'd1);
    endtask

    initial begin
        int w;
        rst     = 1'b1;
        start_v = '0;
        for (int i = 0; i < 4; i++) data_v[i] = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset_tx%0d", i), 32'(tx_v[i]), 32'd1);
            chk($sformatf("reset_busy%0d", i), 32'(busy_v[i]), 32'd0);
        end

        // Single frame 0x02 with a one-cycle request
        data_v[0]  = 8'h02;
        start_v[0] = 1'b1;
        push(8'h02, 0, 1, 104);
        wait_start(0, 4, w);
        chk("latency", 32'(w), 32'd1);
        chk("busy_rise", 32'(busy_v[0]), 32'd1);
        check_frame(0, 1'b0, -1, 8'h00, "f02");

        // Back-to-back frames with tx_start held high
        data_v[0]  = 8'hA5;
        start_v[0] = 1'b1;
        repeat (3) push(8'hA5, 0, 1, 104);
        wait_start(0, 4, w);
        check_frame(0, 1'b1, -1, 8'h00, "a5_0");
        wait_start(0, 4, w);
        chk("b2b_gap1", 32'(w), 32'd1);
        check_frame(0, 1'b1, -1, 8'h00, "a5_1");
        wait_start(0, 4, w);
        chk("b2b_gap2", 32'(w), 32'd1);
        check_frame(0, 1'b0, -1, 8'h00, "a5_2");

        // tx_data changes during data bit 3 must not affect the frame
        data_v[0]  = 8'h55;
        start_v[0] = 1'b1;
        push(8'h55, 0, 1, 104);
        wait_start(0, 4, w);
        check_frame(0, 1'b0, 4 * 104 + 50, 8'hFF, "chg55");

        // Reset mid-data-bit aborts asynchronously
        data_v[0]  = 8'h0F;
        start_v[0] = 1'b1;
        wait_start(0, 4, w);
        start_v[0] = 1'b0;
        repeat (4 * 104 + 40) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_tx", 32'(tx_v[0]), 32'd1);
        chk("abort_busy", 32'(busy_v[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_abort_tx", 32'(tx_v[0]), 32'd1);
        data_v[0]  = 8'h3C;
        start_v[0] = 1'b1;
        push(8'h3C, 0, 1, 104);
        wait_start(0, 4, w);
        chk("post_abort_latency", 32'(w), 32'd1);
        check_frame(0, 1'b0, -1, 8'h00, "f3c");

        // Even parity, two stop bits
        data_v[1]  = 8'h07;
        start_v[1] = 1'b1;
        push(8'h07, 1, 2, 104);
        wait_start(1, 4, w);
        check_frame(1, 1'b0, -1, 8'h00, "even07");

        // Odd parity, two stop bits
        data_v[2]  = 8'h07;
        start_v[2] = 1'b1;
        push(8'h07, 2, 2, 104);
        wait_start(2, 4, w);
        check_frame(2, 1'b0, -1, 8'h00, "odd07");

        // Small truncated divisor: 1 MHz / 300 kbaud -> 3 cycles per bit
        data_v[3]  = 8'hC3;
        start_v[3] = 1'b1;
        push(8'hC3, 0, 1, 3);
        wait_start(3, 4, w);
        check_frame(3, 1'b0, -1, 8'h00, "div3");

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
